// File: rtl/player_vertical.sv
// Per-frame vertical physics and jump/duck state machine for the player avatar.
// Optional build macro FAST_FALL_EN: a duck request in the air dives straight down and lands into a duck.
module player_vertical #(
    parameter int HEIGHT_W = 16,
    parameter int VEL_W    = 12
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                new_frame_in,
    input  logic                jump_in,
    input  logic                duck_in,
    input  logic [5:0]          gravity_in,
    input  logic [7:0]          duck_limit_in,
    input  logic [9:0]          vertical_jump_in,
    output logic [HEIGHT_W-1:0] height_out,
    output logic                airborne_out,
    output logic                ducking_out,
    output logic                landed_out
);

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_AIR    = 2'd1;
    localparam logic [1:0] ST_DUCK   = 2'd2;

    logic [1:0]                r_state,   w_state_nxt;
    logic [HEIGHT_W-1:0]       r_height,  w_height_nxt;
    logic signed [VEL_W-1:0]   r_vel,     w_vel_nxt;
    logic [7:0]                r_cnt,     w_cnt_nxt;
    logic [8:0]                r_limit,   w_limit_nxt;
    logic [5:0]                r_gravity, w_gravity_nxt;
    logic                      r_landed,  w_landed_nxt;
    logic                      r_jump_pend, r_duck_pend;
    logic                      r_airborne, r_ducking;
    logic                      w_jump, w_duck;
    logic [8:0]                w_duck_limit;
    logic signed [HEIGHT_W+1:0] w_nh;
    logic signed [VEL_W-1:0]   w_launch_vel;
    logic signed [VEL_W-1:0]   w_gravity_s;
`ifdef FAST_FALL_EN
    logic [9:0]                r_vj,   w_vj_nxt;
    logic                      r_dive, w_dive_nxt;
`endif

    // A request arriving on the tick cycle itself still counts for that tick.
    assign w_jump       = r_jump_pend | jump_in;
    assign w_duck       = r_duck_pend | duck_in;
    assign w_duck_limit = (duck_limit_in == 8'd0) ? 9'd256 : {1'b0, duck_limit_in};
    assign w_nh         = $signed({2'b00, r_height})
                        + $signed({{(HEIGHT_W+2-VEL_W){r_vel[VEL_W-1]}}, r_vel});
    assign w_launch_vel = $signed({{(VEL_W-10){1'b0}}, vertical_jump_in});
    assign w_gravity_s  = $signed({{(VEL_W-6){1'b0}}, r_gravity});

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_height_nxt  = r_height;
        w_vel_nxt     = r_vel;
        w_cnt_nxt     = r_cnt;
        w_limit_nxt   = r_limit;
        w_gravity_nxt = r_gravity;
        w_landed_nxt  = 1'b0;
`ifdef FAST_FALL_EN
        w_vj_nxt      = r_vj;
        w_dive_nxt    = r_dive;
`endif
        if (new_frame_in) begin
            case (r_state)
                ST_GROUND, ST_DUCK: begin
                    if (w_jump) begin
                        w_state_nxt   = ST_AIR;
                        w_vel_nxt     = w_launch_vel;
                        w_gravity_nxt = gravity_in;
`ifdef FAST_FALL_EN
                        w_vj_nxt      = vertical_jump_in;
`endif
                    end else if (r_state == ST_GROUND) begin
                        if (w_duck) begin
                            w_state_nxt = ST_DUCK;
                            w_cnt_nxt   = 8'd0;
                            w_limit_nxt = w_duck_limit;
                        end
                    end else if ({1'b0, r_cnt} + 9'd1 == r_limit) begin
                        w_state_nxt = ST_GROUND;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_AIR: begin
`ifdef FAST_FALL_EN
                    // The dive tick only redirects velocity; height resumes next tick.
                    if (w_duck) begin
                        w_vel_nxt  = -$signed({{(VEL_W-10){1'b0}}, r_vj});
                        w_dive_nxt = 1'b1;
                    end else
`endif
                    if (w_nh[HEIGHT_W+1] || (w_nh == '0)) begin
                        w_state_nxt  = ST_GROUND;
                        w_height_nxt = '0;
                        w_vel_nxt    = '0;
                        w_landed_nxt = 1'b1;
`ifdef FAST_FALL_EN
                        w_dive_nxt   = 1'b0;
                        if (r_dive) begin
                            w_state_nxt = ST_DUCK;
                            w_cnt_nxt   = 8'd0;
                            w_limit_nxt = w_duck_limit;
                        end
`endif
                    end else begin
                        w_height_nxt = w_nh[HEIGHT_W-1:0];
                        w_vel_nxt    = r_vel - w_gravity_s;
                    end
                end
                default: w_state_nxt = ST_GROUND;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_GROUND;
            r_height    <= '0;
            r_vel       <= '0;
            r_cnt       <= '0;
            r_limit     <= '0;
            r_gravity   <= '0;
            r_landed    <= 1'b0;
            r_jump_pend <= 1'b0;
            r_duck_pend <= 1'b0;
            r_airborne  <= 1'b0;
            r_ducking   <= 1'b0;
`ifdef FAST_FALL_EN
            r_vj        <= '0;
            r_dive      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_height    <= w_height_nxt;
            r_vel       <= w_vel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_limit     <= w_limit_nxt;
            r_gravity   <= w_gravity_nxt;
            r_landed    <= w_landed_nxt;
            r_jump_pend <= new_frame_in ? 1'b0 : w_jump;
            r_duck_pend <= new_frame_in ? 1'b0 : w_duck;
            // Pose flags get their own flops so the outputs never glitch on state decode.
            r_airborne  <= (w_state_nxt == ST_AIR);
            r_ducking   <= (w_state_nxt == ST_DUCK);
`ifdef FAST_FALL_EN
            r_vj        <= w_vj_nxt;
            r_dive      <= w_dive_nxt;
`endif
        end
    end

    assign height_out   = r_height;
    assign airborne_out = r_airborne;
    assign ducking_out  = r_ducking;
    assign landed_out   = r_landed;

endmodule

// File: tb/tb_player_vertical.sv
// Randomised bench for player_vertical: a closed-form trajectory model checked every cycle,
// plus directed scenarios with hand-computed heights and durations.
module tb_player_vertical;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic        jump_in = 1'b0;
    logic        duck_in = 1'b0;
    logic [5:0]  gravity_in = 6'd0;
    logic [7:0]  duck_limit_in = 8'd0;
    logic [9:0]  vertical_jump_in = 10'd0;
    logic [15:0] height_out;
    logic        airborne_out, ducking_out, landed_out;

    int total = 0;
    int bad   = 0;

    player_vertical #(.HEIGHT_W(16), .VEL_W(12)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .new_frame_in     (new_frame_in),
        .jump_in          (jump_in),
        .duck_in          (duck_in),
        .gravity_in       (gravity_in),
        .duck_limit_in    (duck_limit_in),
        .vertical_jump_in (vertical_jump_in),
        .height_out       (height_out),
        .airborne_out     (airborne_out),
        .ducking_out      (ducking_out),
        .landed_out       (landed_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an air segment is a base height, base velocity and tick count,
    // so height follows h = hb + n*vb - g*n*(n-1)/2 directly.
    typedef enum int {M_GROUND, M_AIR, M_DUCK} mode_e;
    mode_e m_mode   = M_GROUND;
    int    m_hb = 0, m_vb = 0, m_n = 0, m_g = 0, m_left = 0;
    bit    m_landed = 0, m_jp = 0, m_dp = 0;
`ifdef FAST_FALL_EN
    int    m_vj = 0;
    bit    m_dive = 0;
`endif

    function automatic int seg_height(input int n);
        return m_hb + n * m_vb - (m_g * n * (n - 1)) / 2;
    endfunction

    function automatic int m_height();
        return (m_mode == M_AIR) ? seg_height(m_n) : 0;
    endfunction

    task automatic m_launch();
        m_mode = M_AIR;
        m_hb   = 0;
        m_vb   = int'(vertical_jump_in);
        m_n    = 0;
        m_g    = int'(gravity_in);
`ifdef FAST_FALL_EN
        m_vj   = int'(vertical_jump_in);
`endif
    endtask

    task automatic m_enter_duck();
        m_mode = M_DUCK;
        m_left = (duck_limit_in == 8'd0) ? 256 : int'(duck_limit_in);
    endtask

    task automatic m_tick(input bit j, input bit d);
        case (m_mode)
            M_GROUND: begin
                if (j) m_launch();
                else if (d) m_enter_duck();
            end
            M_DUCK: begin
                if (j) m_launch();
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_GROUND;
                end
            end
            M_AIR: begin
`ifdef FAST_FALL_EN
                if (d) begin
                    m_hb   = m_height();
                    m_vb   = -m_vj;
                    m_n    = 0;
                    m_dive = 1;
                end else
`endif
                if (seg_height(m_n + 1) <= 0) begin
                    m_landed = 1;
                    m_mode   = M_GROUND;
`ifdef FAST_FALL_EN
                    if (m_dive) m_enter_duck();
                    m_dive = 0;
`endif
                end else begin
                    m_n++;
                end
            end
            default: m_mode = M_GROUND;
        endcase
    endtask

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_mode   = M_GROUND;
            m_landed = 0;
            m_jp     = 0;
            m_dp     = 0;
`ifdef FAST_FALL_EN
            m_dive   = 0;
`endif
        end else begin : step
            bit j, d;
            j = m_jp | jump_in;
            d = m_dp | duck_in;
            m_landed = 0;
            if (new_frame_in) begin
                m_jp = 0;
                m_dp = 0;
                m_tick(j, d);
            end else begin
                m_jp = j;
                m_dp = d;
            end
        end
    end

    always @(negedge clk_in) begin
        check("height",   int'(height_out),   m_height());
        check("airborne", int'(airborne_out), int'(m_mode == M_AIR));
        check("ducking",  int'(ducking_out),  int'(m_mode == M_DUCK));
        check("landed",   int'(landed_out),   int'(m_landed));
    end

    task automatic tick();
        @(negedge clk_in);
        new_frame_in = 1'b1;
        @(negedge clk_in);
        new_frame_in = 1'b0;
    endtask

    task automatic pulse(input bit j, input bit d);
        @(negedge clk_in);
        jump_in = j;
        duck_in = d;
        @(negedge clk_in);
        jump_in = 1'b0;
        duck_in = 1'b0;
    endtask

    task automatic settle();
        int k = 0;
        while ((airborne_out || ducking_out) && k < 600) begin
            tick();
            k++;
        end
        check("settle_ground", int'(airborne_out | ducking_out), 0);
    endtask

    task automatic duck_run(input logic [7:0] lim, input int exp_ticks);
        int cnt = 0;
        duck_limit_in = lim;
        pulse(1'b0, 1'b1);
        tick();
        while (ducking_out && cnt < 400) begin
            cnt++;
            tick();
        end
        check("duck_duration", cnt, exp_ticks);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_height",   int'(height_out),   0);
        check("rst_airborne", int'(airborne_out), 0);
        check("rst_landed",   int'(landed_out),   0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Full parabola with gravity 60, launch velocity 820.
        gravity_in = 6'd60;
        vertical_jump_in = 10'd820;
        pulse(1'b1, 1'b0);
        tick();
        check("launch_h0", int'(height_out), 0);
        check("launch_air", int'(airborne_out), 1);
        tick(); check("tick1_h", int'(height_out), 820);
        tick(); check("tick2_h", int'(height_out), 1580);
        tick(); check("tick3_h", int'(height_out), 2280);
        repeat (11) tick();
        check("peak_h", int'(height_out), 6020);
        repeat (14) tick();
        check("tick28_h", int'(height_out), 280);
        tick();
        check("land_h", int'(height_out), 0);
        check("land_pulse", int'(landed_out), 1);
        check("land_air", int'(airborne_out), 0);
        @(negedge clk_in);
        check("land_pulse_end", int'(landed_out), 0);

        // Parameters change mid-air; trajectory keeps launch values.
        gravity_in = 6'd1;
        vertical_jump_in = 10'd108;
        pulse(1'b1, 1'b0);
        tick();
        gravity_in = 6'd60;
        vertical_jump_in = 10'd820;
        tick(); check("latched_t1", int'(height_out), 108);
        tick(); check("latched_t2", int'(height_out), 215);
        settle();

        duck_run(8'd16, 16);
        duck_run(8'd0, 256);

        // Jump cancels an active duck.
        duck_limit_in = 8'd16;
        pulse(1'b0, 1'b1);
        tick();
        repeat (5) tick();
        pulse(1'b1, 1'b0);
        tick();
        check("cancel_duck", int'(ducking_out), 0);
        check("cancel_air", int'(airborne_out), 1);
        tick();
        check("cancel_vel", int'(height_out), 820);
        settle();

        // Jump beats duck in the same window; a request on the tick cycle itself counts.
        pulse(1'b1, 1'b1);
        tick();
        check("prio_air", int'(airborne_out), 1);
        check("prio_duck", int'(ducking_out), 0);
        settle();
        @(negedge clk_in);
        jump_in = 1'b1;
        new_frame_in = 1'b1;
        @(negedge clk_in);
        jump_in = 1'b0;
        new_frame_in = 1'b0;
        check("same_cycle_jump", int'(airborne_out), 1);
        settle();

        // Duck request in the air: dive when the feature is built in, ignored otherwise.
        gravity_in = 6'd4;
        vertical_jump_in = 10'd220;
        pulse(1'b1, 1'b0);
        tick(); tick(); tick();
        check("ff_pre_h", int'(height_out), 436);
        pulse(1'b0, 1'b1);
        tick();
`ifdef FAST_FALL_EN
        check("ff_dive_h", int'(height_out), 436);
        tick();
        check("ff_fall_h", int'(height_out), 216);
        tick();
        check("ff_land_duck", int'(ducking_out), 1);
        check("ff_land_pulse", int'(landed_out), 1);
`else
        check("ff_ignored_h", int'(height_out), 648);
        check("ff_ignored_air", int'(airborne_out), 1);
`endif
        settle();

        // Asynchronous reset mid-jump clears outputs before any clock edge.
        gravity_in = 6'd60;
        vertical_jump_in = 10'd820;
        pulse(1'b1, 1'b0);
        tick(); tick(); tick();
        check("pre_rst_h", int'(height_out), 1580);
        #2 rst_n_in = 1'b0;
        #1;
        check("async_rst_h", int'(height_out), 0);
        check("async_rst_air", int'(airborne_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Random traffic; gravity floor keeps the peak inside 16 bits.
        repeat (4000) begin
            @(negedge clk_in);
            new_frame_in = ($urandom_range(0, 2) == 0);
            jump_in      = ($urandom_range(0, 9) == 0);
            duck_in      = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) begin
                gravity_in       = 6'($urandom_range(10, 63));
                vertical_jump_in = 10'($urandom_range(0, 1023));
                duck_limit_in    = 8'($urandom_range(0, 255));
            end
        end
        @(negedge clk_in);
        new_frame_in = 1'b0;
        jump_in = 1'b0;
        duck_in = 1'b0;
        repeat (3) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
